result_distributor: RTL and testbench

One-to-four registered result distributor for the multicycle datapath: the write side of the 4:1 operand-select mux. It accepts one result word per handshake and steers it, by a 2-bit destination select, into one of four one-entry holding slots, or into all four when broadcast is requested. Each slot presents its word to its consumer (PC, IR, ALU-out, or memory-data register path) with an independent valid/ready handshake. Back-pressure from any slot propagates to the producer.

---
 rtl/dist_pkg.sv | 24 ++
 rtl/result_slot.sv | 45 ++++
 rtl/result_distributor.sv | 74 +++++++
 tb/tb_result_distributor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// Shared types and constants for the result distributor and its slots.
package dist_pkg;

  localparam int WIDTH     = 32;
  localparam int NUM_SLOTS = 4;

  // One-entry holding slot state.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Slot indices follow the 4:1 operand-select mux encoding.
  localparam logic [1:0] SLOT_A = 2'b00;  // PC path
  localparam logic [1:0] SLOT_B = 2'b01;  // IR path
  localparam logic [1:0] SLOT_C = 2'b10;  // ALU-out path
  localparam logic [1:0] SLOT_D = 2'b11;  // memory-data path

  // Number of set bits in a 4-bit occupancy vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/result_slot.sv
// One-entry holding register with valid/ready on the consumer side.
// A slot that drains this cycle counts as free so it can reload on the same edge.
module result_slot
  import dist_pkg::*;
#(
  parameter int WIDTH = dist_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic             free,
  output logic [WIDTH-1:0] data
);

  slot_state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SLOT_EMPTY;
    else       state_q <= state_d;
  end

  // Next state: load wins over drain, so drain+load stays FULL with new data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load)           state_d = SLOT_FULL;
      SLOT_FULL:  if (ready && !load) state_d = SLOT_EMPTY;
      default:                        state_d = SLOT_EMPTY;
    endcase
  end

  // Data only changes on load; a drained word stays visible with valid low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     data <= '0;
    else if (load) data <= load_data;
  end

  assign valid = (state_q == SLOT_FULL);
  assign free  = !valid || ready;

endmodule

// File: rtl/result_distributor.sv
// One-to-four result distributor: steers each accepted word into one slot
// (unicast) or all four slots (broadcast). in_ready never looks at in_valid.
module result_distributor
  import dist_pkg::*;
#(
  parameter int WIDTH = dist_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [2:0]       pending
);

  logic [NUM_SLOTS-1:0]            target;
  logic [NUM_SLOTS-1:0]            free;
  logic [NUM_SLOTS-1:0]            load;
  logic [NUM_SLOTS-1:0]            full_next;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] slot_data;
  logic                            accept;

  // Destination decode: broadcast hits every slot, otherwise one-hot on sel.
  always_comb begin
    target = '0;
    if (in_bcast) target = '1;
    else          target[in_sel] = 1'b1;
  end

  // Broadcast is all-or-nothing: every slot must be free.
  always_comb begin
    in_ready = 1'b0;
    if (in_bcast) in_ready = &free;
    else          in_ready = free[in_sel];
  end

  assign accept    = in_valid && in_ready;
  assign load      = target & {NUM_SLOTS{accept}};
  assign full_next = load | (out_valid & ~out_ready);

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    result_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .free      (free[k]),
      .data      (slot_data[k])
    );
  end

  assign out_data0 = slot_data[SLOT_A];
  assign out_data1 = slot_data[SLOT_B];
  assign out_data2 = slot_data[SLOT_C];
  assign out_data3 = slot_data[SLOT_D];

  // Occupancy count registered from the same next-state the slots use,
  // so it always matches popcount(out_valid).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= popcount4(full_next);
  end

endmodule

// File: tb/tb_result_distributor.sv
// Self-checking bench for result_distributor: directed scenarios plus a
// randomized run against a per-slot scoreboard.
module tb_result_distributor;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic         in_bcast;
  logic [W-1:0] in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [2:0]   pending;

  int tests = 0;
  int fails = 0;

  // Scoreboard: words expected in each slot, oldest first.
  logic [W-1:0] sb[4][$];

  result_distributor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] od(input int k);
    case (k)
      0: od = out_data0;
      1: od = out_data1;
      2: od = out_data2;
      default: od = out_data3;
    endcase
  endfunction

  function automatic logic model_ready();
    logic [3:0] fr;
    for (int k = 0; k < 4; k++) fr[k] = (sb[k].size() == 0) || out_ready[k];
    model_ready = in_bcast ? (&fr) : fr[in_sel];
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (sb[k].size() != 0);
    model_valid = v;
  endfunction

  // Update the model for the current inputs, then clock; returns #1 after the edge.
  task automatic advance();
    logic acc;
    acc = in_valid && model_ready();
    for (int k = 0; k < 4; k++)
      if (sb[k].size() != 0 && out_ready[k]) void'(sb[k].pop_front());
    if (acc) begin
      for (int k = 0; k < 4; k++)
        if (in_bcast || in_sel == k[1:0]) sb[k].push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_bcast = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    #2;
    tests++;
    if (out_valid !== 4'b0000 || pending !== 3'd0 || out_data0 !== '0 || out_data1 !== '0 ||
        out_data2 !== '0 || out_data3 !== '0) begin
      fails++;
      $display("FAIL reset_state: valid=%b pending=%0d d0=%h d1=%h d2=%h d3=%h expected all zero",
               out_valid, pending, out_data0, out_data1, out_data2, out_data3);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unicast();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEAD_BEEF; out_ready = 4'b0000;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL uni_ready: got %b expected 1", in_ready); end
    advance();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 4'b0100 || out_data2 !== 32'hDEAD_BEEF || pending !== 3'd1) begin
      fails++;
      $display("FAIL uni_load: valid=%b d2=%h pending=%0d expected 0100 deadbeef 1", out_valid, out_data2, pending);
    end
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h0BAD_F00D;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL uni_full_ready: got %b expected 0", in_ready); end
    advance();
    in_valid = 1'b0;
    tests++;
    if (out_data2 !== 32'hDEAD_BEEF || pending !== 3'd1) begin
      fails++; $display("FAIL uni_hold: d2=%h pending=%0d expected deadbeef 1", out_data2, pending);
    end
    out_ready = 4'b0100;
    advance();
    out_ready = 4'b0000;
    tests++;
    if (out_valid !== 4'b0000 || out_data2 !== 32'hDEAD_BEEF || pending !== 3'd0) begin
      fails++; $display("FAIL uni_drain: valid=%b d2=%h pending=%0d expected 0000 deadbeef 0", out_valid, out_data2, pending);
    end
  endtask

  task automatic test_drain_reload();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1111_1111; out_ready = 4'b0000;
    advance();
    in_data = 32'h1234_5678; out_ready = 4'b0010;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reload_ready: got %b expected 1", in_ready); end
    advance();
    in_valid = 1'b0; out_ready = 4'b0000;
    tests++;
    if (out_valid !== 4'b0010 || out_data1 !== 32'h1234_5678 || pending !== 3'd1) begin
      fails++; $display("FAIL reload_data: valid=%b d1=%h pending=%0d expected 0010 12345678 1", out_valid, out_data1, pending);
    end
    out_ready = 4'b0010;
    advance();
    out_ready = 4'b0000;
  endtask

  task automatic test_broadcast();
    in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h3333_3333; out_ready = 4'b0000;
    advance();
    in_bcast = 1'b1; in_sel = 2'd0; in_data = 32'hA5A5_A5A5;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bcast_blocked: got %b expected 0", in_ready); end
    advance();
    out_ready = 4'b1000;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bcast_ready: got %b expected 1", in_ready); end
    advance();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
    tests++;
    if (out_valid !== 4'b1111 || pending !== 3'd4 || out_data0 !== 32'hA5A5_A5A5 || out_data1 !== 32'hA5A5_A5A5 ||
        out_data2 !== 32'hA5A5_A5A5 || out_data3 !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL bcast_load: valid=%b pending=%0d d0=%h d1=%h d2=%h d3=%h expected 1111 4 a5a5a5a5",
               out_valid, pending, out_data0, out_data1, out_data2, out_data3);
    end
    out_ready = 4'b1111;
    advance();
    out_ready = 4'b0000;
    tests++;
    if (out_valid !== 4'b0000 || pending !== 3'd0) begin
      fails++; $display("FAIL bcast_drain: valid=%b pending=%0d expected 0000 0", out_valid, pending);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v;
    out_ready = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      in_valid = 1'b1; in_sel = s[1:0]; in_data = 32'hC0DE_0000 + s;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d: got %b expected 1", s, in_ready); end
      advance();
      exp_v = 4'b0001 << s;
      tests++;
      if (out_valid !== exp_v || od(s) !== 32'hC0DE_0000 + s || pending !== 3'd1) begin
        fails++;
        $display("FAIL b2b_slot%0d: valid=%b data=%h pending=%0d expected %b %h 1", s, out_valid, od(s), pending,
                 exp_v, 32'hC0DE_0000 + s);
      end
    end
    in_valid = 1'b0;
    advance();
    out_ready = 4'b0000;
    tests++;
    if (out_valid !== 4'b0000 || pending !== 3'd0) begin
      fails++; $display("FAIL b2b_end: valid=%b pending=%0d expected 0000 0", out_valid, pending);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h0000_00AA; out_ready = 4'b0000;
    advance();
    in_sel = 2'd3; in_data = 32'h0000_00DD;
    advance();
    idle();
    #2;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) sb[k].delete();
    #1;
    tests++;
    if (out_valid !== 4'b0000 || pending !== 3'd0 || out_data0 !== '0 || out_data3 !== '0) begin
      fails++; $display("FAIL async_reset: valid=%b pending=%0d d0=%h d3=%h expected zeros", out_valid, pending,
                        out_data0, out_data3);
    end
    #2;
    reset = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h5555_0000;
    #1;
    advance();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 4'b0001 || out_data0 !== 32'h5555_0000 || pending !== 3'd1) begin
      fails++; $display("FAIL post_reset: valid=%b d0=%h pending=%0d expected 0001 55550000 1", out_valid, out_data0, pending);
    end
    out_ready = 4'b0001;
    advance();
    out_ready = 4'b0000;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bcast  = ($urandom_range(0, 7) == 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom();
      out_ready = 4'($urandom_range(0, 15));
      #1;
      tests++;
      if (in_ready !== model_ready()) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, model_ready());
      end
      tests++;
      if (out_valid !== model_valid() || pending !== 3'($countones(model_valid())) ||
          pending !== 3'($countones(out_valid))) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL rnd_occupancy c=%0d: valid=%b pending=%0d expected %b", c, out_valid, pending,
                               model_valid());
      end
      for (int k = 0; k < 4; k++) begin
        if (sb[k].size() != 0) begin
          tests++;
          if (od(k) !== sb[k][0]) begin
            fails++; bad++;
            if (bad < 10) $display("FAIL rnd_data%0d c=%0d: got %h expected %h", k, c, od(k), sb[k][0]);
          end
        end
      end
      advance();
    end
    idle();
    out_ready = 4'b1111;
    advance();
    out_ready = 4'b0000;
    tests++;
    if (out_valid !== 4'b0000 || pending !== 3'd0) begin
      fails++; $display("FAIL rnd_flush: valid=%b pending=%0d expected 0000 0", out_valid, pending);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_drain_reload();
    test_broadcast();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
